// File: rtl/mcpu_mem_l1_arb_pkg.sv
// mcpu_mem_l1_arb_pkg: shared definitions for the L1-to-memory-arbiter atom port.
//   - Atom field widths (opcode, line address [31:5], line data, byte enables).
//   - Atom opcode encodings (carried through the arbiter untouched).
//   - Arbiter FSM state encoding.
//   - idx_width(): width of a requester index, never less than one bit.
package mcpu_mem_l1_arb_pkg;

   localparam int unsigned OPC_W  = 3;
   localparam int unsigned ADDR_W = 27;
   localparam int unsigned LINE_W = 256;
   localparam int unsigned BE_W   = 32;

   typedef enum logic [2:0] {
      OpRead     = 3'd0,
      OpWrite    = 3'd1,
      OpPrefetch = 3'd2,
      OpFlush    = 3'd3
   } atom_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } arb_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mcpu_mem_l1_arb_if.sv
// mcpu_mem_l1_arb_if: bundle of the requester-side and downstream-side atom signals.
//   req_valid/opcode/addr/wdata/wbe  requesters -> arbiter, slice i belongs to requester i
//   req_stall/req_rvalid             arbiter -> requesters, one bit per requester
//   req_rdata                        arbiter -> requesters, broadcast response line
//   arb_valid/opcode/addr/wdata/wbe  arbiter -> memory arbiter
//   arb_stall/arb_rvalid/arb_rdata   memory arbiter -> arbiter
// Modports: slave = the L1 arbiter itself, master = the environment around it.
interface mcpu_mem_l1_arb_if
   import mcpu_mem_l1_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2
) ();

   logic [N_REQ-1:0]        req_valid;
   logic [OPC_W*N_REQ-1:0]  req_opcode;
   logic [ADDR_W*N_REQ-1:0] req_addr;
   logic [LINE_W*N_REQ-1:0] req_wdata;
   logic [BE_W*N_REQ-1:0]   req_wbe;
   logic [N_REQ-1:0]        req_stall;
   logic [N_REQ-1:0]        req_rvalid;
   logic [LINE_W-1:0]       req_rdata;

   logic                    arb_valid;
   logic [OPC_W-1:0]        arb_opcode;
   logic [ADDR_W-1:0]       arb_addr;
   logic [LINE_W-1:0]       arb_wdata;
   logic [BE_W-1:0]         arb_wbe;
   logic                    arb_stall;
   logic                    arb_rvalid;
   logic [LINE_W-1:0]       arb_rdata;

   modport slave (
      input  req_valid, req_opcode, req_addr, req_wdata, req_wbe,
      input  arb_stall, arb_rvalid, arb_rdata,
      output req_stall, req_rvalid, req_rdata,
      output arb_valid, arb_opcode, arb_addr, arb_wdata, arb_wbe
   );

   modport master (
      output req_valid, req_opcode, req_addr, req_wdata, req_wbe,
      output arb_stall, arb_rvalid, arb_rdata,
      input  req_stall, req_rvalid, req_rdata,
      input  arb_valid, arb_opcode, arb_addr, arb_wdata, arb_wbe
   );

endinterface

// File: rtl/mcpu_mem_rr_pick.sv
// mcpu_mem_rr_pick: combinational N-way requester picker.
//   valid      in   N_REQ   request vector
//   last       in   IDX_W   index served most recently
//   any        out  1       at least one request present
//   grant      out  N_REQ   one-hot winner (all zero when any=0)
//   grant_idx  out  IDX_W   binary winner index (0 when any=0)
// RR_ENABLE=1: first valid index strictly after last, wrapping.
// RR_ENABLE=0: lowest valid index, last is ignored.
module mcpu_mem_rr_pick
   import mcpu_mem_l1_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned RR_ENABLE = 1,
   localparam int unsigned IDX_W    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] last,
   output logic             any,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic found;

   always_comb begin
      any       = |valid;
      found     = 1'b0;
      grant_idx = '0;
      if (RR_ENABLE != 0) begin
         for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned cand;
            cand = (32'(last) + k) % N_REQ;
            if (!found && valid[cand]) begin
               found     = 1'b1;
               grant_idx = IDX_W'(cand);
            end
         end
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && valid[i]) begin
               found     = 1'b1;
               grant_idx = IDX_W'(i);
            end
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         grant[i] = found && (grant_idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/mcpu_mem_l1_arb.sv
// mcpu_mem_l1_arb: shares the single line-sized memory-arbiter atom port among the L1 caches
// (requester 0 = il1c, 1 = dl1c). One atom outstanding at a time; a grant is held from first
// presentation until its response returns, so each requester sees the plain atom protocol.
//   clkrst_mem_clk    in  clock
//   clkrst_mem_rst_n  in  synchronous active-low reset
//   bus               mcpu_mem_l1_arb_if.slave: requester and downstream atom signals
module mcpu_mem_l1_arb
   import mcpu_mem_l1_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned RR_ENABLE = 1
) (
   input logic              clkrst_mem_clk,
   input logic              clkrst_mem_rst_n,
   mcpu_mem_l1_arb_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(N_REQ);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] sel;
   int unsigned      sel_base;

   logic             pick_any;
   logic [N_REQ-1:0] pick_grant;
   logic [IDX_W-1:0] pick_idx;

   logic             arb_valid_c;
   logic [N_REQ-1:0] stall_c;
   logic [N_REQ-1:0] rvalid_c;

   mcpu_mem_rr_pick #(
      .N_REQ     (N_REQ),
      .RR_ENABLE (RR_ENABLE)
   ) u_pick (
      .valid     (bus.req_valid),
      .last      (last_q),
      .any       (pick_any),
      .grant     (pick_grant),
      .grant_idx (pick_idx)
   );

   // last resets to N_REQ-1 so requester 0 wins the first tie.
   always_ff @(posedge clkrst_mem_clk) begin
      if (!clkrst_mem_rst_n) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      sel         = owner_q;
      arb_valid_c = 1'b0;
      stall_c     = '1;
      rvalid_c    = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               sel         = pick_idx;
               arb_valid_c = 1'b1;
               owner_d     = pick_idx;
               if (!bus.arb_stall) begin
                  stall_c = ~pick_grant;
                  state_d = StWait;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            // Grant is frozen here; losing the owner's valid abandons the atom.
            if (bus.req_valid[owner_q]) begin
               arb_valid_c = 1'b1;
               if (!bus.arb_stall) begin
                  stall_c[owner_q] = 1'b0;
                  state_d          = StWait;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (bus.arb_rvalid) begin
               rvalid_c[owner_q] = 1'b1;
               last_d            = owner_q;
               state_d           = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign sel_base = 32'(sel);

   assign bus.arb_opcode = bus.req_opcode[sel_base*OPC_W +: OPC_W];
   assign bus.arb_addr   = bus.req_addr[sel_base*ADDR_W +: ADDR_W];
   assign bus.arb_wdata  = bus.req_wdata[sel_base*LINE_W +: LINE_W];
   assign bus.arb_wbe    = bus.req_wbe[sel_base*BE_W +: BE_W];

   // Outputs are forced quiet while reset is held, independent of the registered state.
   assign bus.arb_valid  = arb_valid_c & clkrst_mem_rst_n;
   assign bus.req_stall  = stall_c | {N_REQ{~clkrst_mem_rst_n}};
   assign bus.req_rvalid = rvalid_c & {N_REQ{clkrst_mem_rst_n}};
   assign bus.req_rdata  = bus.arb_rdata;

endmodule

// File: tb/tb_mcpu_mem_l1_arb.sv
module tb_mcpu_mem_l1_arb;
   import mcpu_mem_l1_arb_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mcpu_mem_l1_arb_if #(.N_REQ(N)) bus ();

   mcpu_mem_l1_arb #(
      .N_REQ     (N),
      .RR_ENABLE (1)
   ) dut (
      .clkrst_mem_clk   (clk),
      .clkrst_mem_rst_n (rst_n),
      .bus              (bus)
   );

   int checks = 0;
   int errors = 0;

   // Requester-side stimulus: an atom stays pending until its response is predicted.
   bit           pend   [N];
   logic [2:0]   r_op   [N];
   logic [26:0]  r_addr [N];
   logic [255:0] r_wd   [N];
   logic [31:0]  r_be   [N];

   bit auto_req = 0, auto_mem = 0;
   int req_pct = 50, stall_pct = 0, max_lat = 0;
   bit man_stall = 0, man_rvalid = 0;
   bit mem_busy = 0;
   int mem_cnt = 0;

   // Reference model: who holds the port, whether the atom has been taken, who was served last.
   int m_grant = -1;
   bit m_acc = 0;
   int m_last = N - 1;

   // Observations from the most recent step.
   logic [N-1:0] last_rv;
   logic [26:0]  last_addr;
   int           obs_grants[$];

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic stall_v, input logic rv_v, input logic [255:0] rd_v);
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]          = pend[i];
         bus.req_opcode[3*i +: 3]  = r_op[i];
         bus.req_addr[27*i +: 27]  = r_addr[i];
         bus.req_wdata[256*i +: 256] = r_wd[i];
         bus.req_wbe[32*i +: 32]   = r_be[i];
      end
      bus.arb_stall  = stall_v;
      bus.arb_rvalid = rv_v;
      bus.arb_rdata  = rd_v;
   endtask

   task automatic new_atom(input int i);
      pend[i]   = 1'b1;
      r_op[i]   = 3'($urandom_range(0, 3));
      r_addr[i] = 27'($urandom);
      r_wd[i]   = rand_line();
      r_be[i]   = $urandom;
   endtask

   // One clock cycle: drive at posedge+1, check at posedge+4, advance the model.
   task automatic step();
      logic stall_v, rv_v;
      logic [255:0] rd_v;
      bit exp_valid, accepted_now;
      int sel;
      logic [N-1:0] exp_stall, exp_rv;

      if (auto_req)
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(1, 100) <= req_pct) new_atom(i);
      if (auto_mem) begin
         stall_v = ($urandom_range(1, 100) <= stall_pct);
         if (mem_busy) begin
            rv_v = (mem_cnt == 0);
            if (mem_cnt > 0) mem_cnt--;
         end else begin
            rv_v = ($urandom_range(0, 7) == 0);
         end
      end else begin
         stall_v = man_stall;
         rv_v    = man_rvalid;
      end
      rd_v = rand_line();
      drive(stall_v, rv_v, rd_v);
      #3;

      exp_valid = 0;
      accepted_now = 0;
      sel = -1;
      exp_stall = '1;
      exp_rv = '0;
      if (m_grant < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (sel < 0 && pend[c]) sel = c;
         end
         if (sel >= 0) m_grant = sel;
      end else if (!m_acc) begin
         sel = m_grant;
      end else if (rv_v) begin
         exp_rv[m_grant] = 1'b1;
         m_last  = m_grant;
         m_grant = -1;
         m_acc   = 0;
      end
      if (sel >= 0) begin
         exp_valid = 1;
         exp_stall[sel] = stall_v;
         if (!stall_v) begin
            m_acc = 1;
            accepted_now = 1;
         end
      end

      chk("arb_valid", bus.arb_valid, exp_valid);
      if (exp_valid) begin
         chk("arb_addr", bus.arb_addr, r_addr[sel]);
         chk("arb_opcode", bus.arb_opcode, r_op[sel]);
         chk("arb_wdata", bus.arb_wdata, r_wd[sel]);
         chk("arb_wbe", bus.arb_wbe, r_be[sel]);
      end
      chk("req_stall", bus.req_stall, exp_stall);
      chk("req_rvalid", bus.req_rvalid, exp_rv);
      chk("req_rdata", bus.req_rdata, rd_v);

      last_rv = bus.req_rvalid;
      last_addr = bus.arb_addr;
      for (int i = 0; i < N; i++)
         if (bus.arb_valid && !bus.req_stall[i]) obs_grants.push_back(i);

      for (int i = 0; i < N; i++) if (exp_rv[i]) pend[i] = 0;
      if (accepted_now) begin
         mem_busy = 1;
         mem_cnt = $urandom_range(0, max_lat);
      end else if (mem_busy && rv_v) begin
         mem_busy = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // One cycle with reset low: outputs must be quiet even with requests and a response present.
   task automatic rst_step();
      rst_n = 1'b0;
      drive(1'b0, 1'b1, rand_line());
      #3;
      chk("rst_arb_valid", bus.arb_valid, 1'b0);
      chk("rst_req_rvalid", bus.req_rvalid, '0);
      chk("rst_req_stall", bus.req_stall, 2'b11);
      m_grant = -1;
      m_acc = 0;
      m_last = N - 1;
      mem_busy = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [26:0] a0;

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 0;
         r_op[i] = '0;
         r_addr[i] = '0;
         r_wd[i] = '0;
         r_be[i] = '0;
      end
      drive(1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      rst_step();
      rst_step();

      // Reset state, then a spurious response in IDLE.
      step();
      man_rvalid = 1;
      step();
      man_rvalid = 0;

      // Single requester, zero-cycle pass-through, response three cycles later.
      pend[0] = 1;
      r_op[0] = OpRead;
      r_addr[0] = 27'h0000100;
      r_wd[0] = rand_line();
      r_be[0] = 32'hFFFF_FFFF;
      step();
      chk("t1_addr", last_addr, 27'h0000100);
      step();
      step();
      man_rvalid = 1;
      step();
      chk("t1_rvalid", last_rv, 2'b01);
      man_rvalid = 0;

      // Reset while an atom is in WAIT; first post-reset tie goes to requester 0.
      new_atom(0);
      step();
      step();
      rst_step();
      new_atom(0);
      new_atom(1);
      r_addr[0] = 27'h0AAAAAA;
      r_addr[1] = 27'h1555555;
      man_rvalid = 1;
      step();
      chk("t5_tie", last_addr, 27'h0AAAAAA);
      for (int i = 0; i < 4; i++) step();
      man_rvalid = 0;

      // Both valid every cycle, zero-latency responses: grants alternate with a bubble.
      auto_req = 1;
      req_pct = 100;
      auto_mem = 1;
      stall_pct = 0;
      max_lat = 0;
      obs_grants.delete();
      for (int i = 0; i < 8; i++) step();
      chk("t2_count", 32'(obs_grants.size()), 32'd4);
      if (obs_grants.size() == 4) begin
         chk("t2_g0", 32'(obs_grants[0]), 32'd0);
         chk("t2_g1", 32'(obs_grants[1]), 32'd1);
         chk("t2_g2", 32'(obs_grants[2]), 32'd0);
         chk("t2_g3", 32'(obs_grants[3]), 32'd1);
      end

      // Stall held for four cycles: presented address must not move.
      stall_pct = 100;
      step();
      a0 = last_addr;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold", last_addr, a0);
      end
      stall_pct = 0;
      step();

      // Randomized traffic against the model.
      req_pct = 40;
      stall_pct = 30;
      max_lat = 3;
      for (int i = 0; i < 2000; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
